// File: rtl/showtank_auto.sv
// showtank_auto: attract/demo-mode tank mover for the tile-grid playfield.
// Steps one tile per step_tick from a loaded start pose; wrap or bounce at
// the edges, and requests a shot every FIRE_PERIOD steps via bul_sht.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   enable              run/freeze control
//   step_tick           single-cycle move strobe
//   load                single-cycle pulse, capture start_x/start_y/start_dir
//   start_x, start_y    start tile (clamped into the grid)
//   start_dir           00 up, 01 down, 10 left, 11 right
//   bul_state_feedback  1 while this tank's bullet is in flight
//   x_rel_pos_out       current tile x
//   y_rel_pos_out       current tile y
//   tank_dir_out        current direction
//   bul_sht             one-cycle fire request
//   active              pose loaded and enable high (registered)
module showtank_auto #(
  parameter int GRID_W      = 25,
  parameter int GRID_H      = 13,
  parameter int POS_W       = 5,
  parameter int BOUNCE      = 0,
  parameter int FIRE_PERIOD = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             step_tick,
  input  logic             load,
  input  logic [POS_W-1:0] start_x,
  input  logic [POS_W-1:0] start_y,
  input  logic [1:0]       start_dir,
  input  logic             bul_state_feedback,
  output logic [POS_W-1:0] x_rel_pos_out,
  output logic [POS_W-1:0] y_rel_pos_out,
  output logic [1:0]       tank_dir_out,
  output logic             bul_sht,
  output logic             active
);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [POS_W-1:0] X_MAX = POS_W'(GRID_W - 1);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(GRID_H - 1);
  // One extra bit so a grid of exactly 2^POS_W tiles still compares right.
  localparam logic [POS_W:0]   W_LIM = (POS_W + 1)'(GRID_W);
  localparam logic [POS_W:0]   H_LIM = (POS_W + 1)'(GRID_H);

  localparam bit FIRE_EN = (FIRE_PERIOD > 0);
  localparam int CNT_W   = $clog2((FIRE_PERIOD > 1) ? FIRE_PERIOD : 2);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((FIRE_PERIOD > 0) ? FIRE_PERIOD - 1 : 0);

  localparam int TMR_W = $clog2((ACK_TIMEOUT > 1) ? ACK_TIMEOUT : 2);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_READY,
    S_WAIT_ACK,
    S_WAIT_DONE
  } fire_state_e;

  logic [POS_W-1:0] x_q;
  logic [POS_W-1:0] y_q;
  logic [1:0]       dir_q;
  logic             loaded_q;
  logic             active_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pend_q;
  logic             sht_q;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  fire_state_e      state_q;
  fire_state_e      state_d;

  logic [POS_W-1:0] ld_x;
  logic [POS_W-1:0] ld_y;
  logic [POS_W-1:0] x_mv;
  logic [POS_W-1:0] y_mv;
  logic [1:0]       dir_mv;
  logic             at_edge;
  logic             step;
  logic             fire_hit;
  logic             issue;

  assign ld_x = ({1'b0, start_x} >= W_LIM) ? X_MAX : start_x;
  assign ld_y = ({1'b0, start_y} >= H_LIM) ? Y_MAX : start_y;

  assign step     = step_tick & enable & loaded_q & ~load;
  assign fire_hit = FIRE_EN & step & (cnt_q == CNT_LAST);

  always_comb begin
    at_edge = 1'b0;
    unique case (dir_q)
      DIR_UP:    at_edge = (y_q == '0);
      DIR_DOWN:  at_edge = (y_q == Y_MAX);
      DIR_LEFT:  at_edge = (x_q == '0);
      DIR_RIGHT: at_edge = (x_q == X_MAX);
      default:   at_edge = 1'b0;
    endcase
  end

  // In bounce mode the flipped direction can never be at an edge too
  // (grid is at least 2 wide), so the wrap arithmetic below is only
  // exercised in wrap mode.
  always_comb begin
    dir_mv = dir_q;
    if (BOUNCE != 0 && at_edge) begin
      dir_mv = dir_q ^ 2'b01;
    end
    x_mv = x_q;
    y_mv = y_q;
    unique case (dir_mv)
      DIR_UP:
        y_mv = (y_q == '0) ? Y_MAX : y_q - POS_W'(1);
      DIR_DOWN:
        y_mv = (y_q == Y_MAX) ? '0 : y_q + POS_W'(1);
      DIR_LEFT:
        x_mv = (x_q == '0) ? X_MAX : x_q - POS_W'(1);
      DIR_RIGHT:
        x_mv = (x_q == X_MAX) ? '0 : x_q + POS_W'(1);
      default: begin
        x_mv = x_q;
        y_mv = y_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= DIR_UP;
      loaded_q <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      if (load) begin
        x_q      <= ld_x;
        y_q      <= ld_y;
        dir_q    <= start_dir;
        loaded_q <= 1'b1;
        cnt_q    <= '0;
        pend_q   <= 1'b0;
      end else begin
        if (step) begin
          x_q   <= x_mv;
          y_q   <= y_mv;
          dir_q <= dir_mv;
          if (FIRE_EN) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
          end
        end
        // A new period boundary beats the clear from a shot issued now.
        if (fire_hit) begin
          pend_q <= 1'b1;
        end else if (issue) begin
          pend_q <= 1'b0;
        end
      end
      active_q <= enable & (loaded_q | load);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_READY;
      tmr_q   <= '0;
      sht_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      sht_q   <= issue;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    issue   = 1'b0;
    unique case (state_q)
      S_READY: begin
        if (pend_q && !bul_state_feedback && enable) begin
          issue   = 1'b1;
          tmr_d   = '0;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (bul_state_feedback) begin
          state_d = S_WAIT_DONE;
        end else if (tmr_q == TMR_LAST) begin
          state_d = S_READY;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!bul_state_feedback) begin
          state_d = S_READY;
        end
      end
      default: state_d = S_READY;
    endcase
  end

  assign x_rel_pos_out = x_q;
  assign y_rel_pos_out = y_q;
  assign tank_dir_out  = dir_q;
  assign bul_sht       = sht_q & enable;
  assign active        = active_q;

endmodule

// File: tb/tb_showtank_auto.sv
// tb_showtank_auto: checks a wrap-mode and a bounce-mode showtank_auto
// against a behavioural model, a vector table and hand-written sequences.
module tb_showtank_auto;

  localparam int W  = 25;
  localparam int H  = 13;
  localparam int FP = 4;
  localparam int AT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       step_tick = 1'b0;
  logic       load = 1'b0;
  logic [4:0] start_x = '0;
  logic [4:0] start_y = '0;
  logic [1:0] start_dir = '0;
  logic       fb = 1'b0;

  logic [4:0] xw, yw, xb, yb;
  logic [1:0] dw, db;
  logic       shw, shb, acw, acb;

  always #5 clk = ~clk;

  showtank_auto #(
    .GRID_W(W), .GRID_H(H), .POS_W(5), .BOUNCE(0),
    .FIRE_PERIOD(FP), .ACK_TIMEOUT(AT)
  ) dut_w (
    .clk(clk), .rst(rst), .enable(enable), .step_tick(step_tick),
    .load(load), .start_x(start_x), .start_y(start_y),
    .start_dir(start_dir), .bul_state_feedback(fb),
    .x_rel_pos_out(xw), .y_rel_pos_out(yw), .tank_dir_out(dw),
    .bul_sht(shw), .active(acw)
  );

  showtank_auto #(
    .GRID_W(W), .GRID_H(H), .POS_W(5), .BOUNCE(1),
    .FIRE_PERIOD(FP), .ACK_TIMEOUT(AT)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .step_tick(step_tick),
    .load(load), .start_x(start_x), .start_y(start_y),
    .start_dir(start_dir), .bul_state_feedback(fb),
    .x_rel_pos_out(xb), .y_rel_pos_out(yb), .tank_dir_out(db),
    .bul_sht(shb), .active(acb)
  );

  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;

  // Model state, index 0 = wrap instance, 1 = bounce instance.
  // phase: 0 ready, 1 awaiting ack, 2 awaiting bullet done.
  int mx[2], my[2], md[2], mcnt[2], mph[2], mtmr[2];
  bit mld[2], mpend[2], msht[2], mact[2];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      bit stp, iss, edge_hit;
      int d, dx, dy;
      if (rst) begin
        mx[m] = 0; my[m] = 0; md[m] = 0; mld[m] = 0; mact[m] = 0;
        mcnt[m] = 0; mpend[m] = 0; mph[m] = 0; mtmr[m] = 0; msht[m] = 0;
      end else begin
        stp = step_tick && enable && mld[m] && !load;
        iss = (mph[m] == 0) && mpend[m] && !fb && enable;
        case (mph[m])
          0: if (iss) begin mph[m] = 1; mtmr[m] = 0; end
          1: if (fb) mph[m] = 2;
             else begin
               mtmr[m]++;
               if (mtmr[m] == AT) mph[m] = 0;
             end
          default: if (!fb) mph[m] = 0;
        endcase
        msht[m] = iss;
        if (load) begin
          mcnt[m] = 0;
          mpend[m] = 0;
          mx[m] = (int'(start_x) >= W) ? W - 1 : int'(start_x);
          my[m] = (int'(start_y) >= H) ? H - 1 : int'(start_y);
          md[m] = int'(start_dir);
        end else begin
          if (iss) mpend[m] = 0;
          if (stp) begin
            if (mcnt[m] == FP - 1) mpend[m] = 1;
            mcnt[m] = (mcnt[m] + 1) % FP;
            d = md[m];
            edge_hit = (d == 0 && my[m] == 0) || (d == 1 && my[m] == H - 1) ||
                       (d == 2 && mx[m] == 0) || (d == 3 && mx[m] == W - 1);
            if (m == 1 && edge_hit) d = d ^ 1;
            dx = 0; dy = 0;
            case (d)
              0: dy = -1;
              1: dy = 1;
              2: dx = -1;
              default: dx = 1;
            endcase
            mx[m] = (mx[m] + dx + W) % W;
            my[m] = (my[m] + dy + H) % H;
            md[m] = d;
          end
        end
        if (load) mld[m] = 1;
        mact[m] = enable && mld[m];
      end
    end
  endtask

  task automatic check_all();
    chk("w_x", 32'(xw), 32'(mx[0]));
    chk("w_y", 32'(yw), 32'(my[0]));
    chk("w_dir", 32'(dw), 32'(md[0]));
    chk("w_sht", 32'(shw), 32'(msht[0] && enable));
    chk("w_act", 32'(acw), 32'(mact[0]));
    chk("b_x", 32'(xb), 32'(mx[1]));
    chk("b_y", 32'(yb), 32'(my[1]));
    chk("b_dir", 32'(db), 32'(md[1]));
    chk("b_sht", 32'(shb), 32'(msht[1] && enable));
    chk("b_act", 32'(acb), 32'(mact[1]));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    if (shw) pulses++;
  endtask

  task automatic do_load(int x, int y, int d);
    load = 1'b1;
    start_x = 5'(x);
    start_y = 5'(y);
    start_dir = 2'(d);
    cycle();
    load = 1'b0;
  endtask

  task automatic ack();
    fb = 1'b1;
    cycle();
    cycle();
    fb = 1'b0;
    cycle();
  endtask

  typedef struct {
    bit ld; int sx; int sy; int sd; bit en; bit tk;
    int wx; int wy; int wd; int bx; int by; int bd;
  } vec_t;

  vec_t vt[14];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int got;
    vt[0]  = '{1, 3, 0, 0, 1, 0,   3, 0, 0,   3, 0, 0};
    vt[1]  = '{0, 0, 0, 0, 1, 1,   3, 12, 0,  3, 1, 1};
    vt[2]  = '{1, 24, 5, 3, 1, 0,  24, 5, 3,  24, 5, 3};
    vt[3]  = '{0, 0, 0, 0, 1, 1,   0, 5, 3,   23, 5, 2};
    vt[4]  = '{1, 23, 4, 3, 1, 0,  23, 4, 3,  23, 4, 3};
    vt[5]  = '{0, 0, 0, 0, 1, 1,   24, 4, 3,  24, 4, 3};
    vt[6]  = '{0, 0, 0, 0, 1, 1,   0, 4, 3,   23, 4, 2};
    vt[7]  = '{1, 0, 0, 0, 1, 0,   0, 0, 0,   0, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 1, 1,   0, 12, 0,  0, 1, 1};
    vt[9]  = '{1, 30, 20, 2, 1, 1, 24, 12, 2, 24, 12, 2};
    vt[10] = '{0, 0, 0, 0, 1, 1,   23, 12, 2, 23, 12, 2};
    vt[11] = '{0, 0, 0, 0, 0, 1,   23, 12, 2, 23, 12, 2};
    vt[12] = '{0, 0, 0, 0, 0, 1,   23, 12, 2, 23, 12, 2};
    vt[13] = '{0, 0, 0, 0, 1, 0,   23, 12, 2, 23, 12, 2};

    rst = 1'b1;
    cycle();
    cycle();
    chk("reset_x", 32'(xw), 0);
    chk("reset_act", 32'(acw), 0);
    chk("reset_sht", 32'(shw), 0);
    rst = 1'b0;
    cycle();

    // Motion table: wrap, bounce, clamp and load-over-tick priority.
    for (int i = 0; i < 14; i++) begin
      load = vt[i].ld;
      start_x = 5'(vt[i].sx);
      start_y = 5'(vt[i].sy);
      start_dir = 2'(vt[i].sd);
      enable = vt[i].en;
      step_tick = vt[i].tk;
      cycle();
      chk($sformatf("vec%0d_wx", i), 32'(xw), 32'(vt[i].wx));
      chk($sformatf("vec%0d_wy", i), 32'(yw), 32'(vt[i].wy));
      chk($sformatf("vec%0d_wd", i), 32'(dw), 32'(vt[i].wd));
      chk($sformatf("vec%0d_bx", i), 32'(xb), 32'(vt[i].bx));
      chk($sformatf("vec%0d_by", i), 32'(yb), 32'(vt[i].by));
      chk($sformatf("vec%0d_bd", i), 32'(db), 32'(vt[i].bd));
      load = 1'b0;
      step_tick = 1'b0;
    end
    chk("active_after_table", 32'(acw), 1);

    // Fire cadence: shot one cycle after every 4th tick, ack'ed.
    enable = 1'b1;
    do_load(5, 5, 3);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      step_tick = 1'b1;
      cycle();
      step_tick = 1'b0;
      chk("cad_no_early", 32'(shw), 0);
      cycle();
      chk("cad_pulse", 32'(shw), 32'(k % 4 == 0));
      if (k % 4 == 0) begin
        fb = 1'b1;
        cycle();
        chk("cad_width", 32'(shw), 0);
        cycle();
        cycle();
        fb = 1'b0;
        cycle();
      end
    end
    chk("cad_count", 32'(pulses), 2);

    // Blocked by a bullet in flight, fires once it lands.
    fb = 1'b1;
    do_load(5, 5, 3);
    for (int k = 0; k < 4; k++) begin
      step_tick = 1'b1;
      cycle();
    end
    step_tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("blocked", 32'(shw), 0);
    end
    fb = 1'b0;
    cycle();
    chk("unblocked_pulse", 32'(shw), 1);
    ack();

    // Lost shot: no ack, next request goes out once the wait expires.
    do_load(5, 5, 3);
    for (int k = 0; k < 4; k++) begin
      step_tick = 1'b1;
      cycle();
    end
    step_tick = 1'b0;
    cycle();
    chk("to_first_pulse", 32'(shw), 1);
    got = 0;
    for (int i = 1; i <= 20; i++) begin
      step_tick = (i <= 4);
      cycle();
      if (shw && got == 0) got = i;
    end
    step_tick = 1'b0;
    chk("timeout_refire", 32'(got), 11);
    ack();

    // Freeze with a pending request.
    do_load(10, 6, 1);
    for (int k = 0; k < 4; k++) begin
      step_tick = 1'b1;
      cycle();
    end
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("frz_y", 32'(yw), 10);
      chk("frz_sht", 32'(shw), 0);
    end
    chk("frz_act", 32'(acw), 0);
    step_tick = 1'b0;
    enable = 1'b1;
    cycle();
    chk("unfreeze_pulse", 32'(shw), 1);
    ack();

    // Reset while awaiting an ack.
    do_load(2, 2, 2);
    for (int k = 0; k < 4; k++) begin
      step_tick = 1'b1;
      cycle();
    end
    step_tick = 1'b0;
    cycle();
    chk("pre_rst_pulse", 32'(shw), 1);
    rst = 1'b1;
    cycle();
    chk("rst_x", 32'(xw), 0);
    chk("rst_y", 32'(yw), 0);
    chk("rst_dir", 32'(dw), 0);
    chk("rst_act", 32'(acw), 0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step_tick = 1'b1;
      cycle();
    end
    step_tick = 1'b0;
    chk("post_rst_pulses", 32'(pulses), 0);
    chk("post_rst_x", 32'(xw), 0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(255) == 0);
      load = ($urandom_range(11) == 0);
      start_x = 5'($urandom_range(31));
      start_y = 5'($urandom_range(31));
      start_dir = 2'($urandom_range(3));
      enable = ($urandom_range(7) != 0);
      step_tick = $urandom_range(1);
      if ($urandom_range(3) == 0) fb = ~fb;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
